// File: rtl/simon_req_arbiter_if.sv
// Requester, core and response signals of the SIMON job arbiter.
interface simon_req_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) ();
    logic [N_REQ-1:0]     req_valid_i;
    logic [N_REQ-1:0]     req_ready_o;
    logic [N_REQ*128-1:0] req_pt_i;
    logic [N_REQ*128-1:0] req_key_i;
    logic                 core_start_o;
    logic [127:0]         core_pt_o;
    logic [127:0]         core_k0_o;
    logic                 core_valid_i;
    logic [127:0]         core_ct_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [ID_W-1:0]      rsp_id_o;
    logic [127:0]         rsp_ct_o;
    logic                 rsp_err_o;
    logic                 busy_o;
    logic [15:0]          done_cnt_o;

    // Arbiter side
    modport slave (
        input  req_valid_i, req_pt_i, req_key_i, core_valid_i, core_ct_i, rsp_ready_i,
        output req_ready_o, core_start_o, core_pt_o, core_k0_o,
               rsp_valid_o, rsp_id_o, rsp_ct_o, rsp_err_o, busy_o, done_cnt_o
    );

    // Requester / core / response-consumer side
    modport master (
        output req_valid_i, req_pt_i, req_key_i, core_valid_i, core_ct_i, rsp_ready_i,
        input  req_ready_o, core_start_o, core_pt_o, core_k0_o,
               rsp_valid_o, rsp_id_o, rsp_ct_o, rsp_err_o, busy_o, done_cnt_o
    );
endinterface

// File: rtl/simon_req_arbiter.sv
// Round-robin scheduler sharing one SIMON 128/128 core between N_REQ requesters.
module simon_req_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = $clog2(N_REQ),
    parameter int unsigned TIMEOUT = 96
) (
    input  logic               clk,
    input  logic               rst_n,
    simon_req_arbiter_if.slave bus_if
);
    localparam int unsigned DATA_W = 128;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_LOW,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     w_win_idx;
    logic                w_found;
    logic [DATA_W-1:0]   w_win_pt;
    logic [DATA_W-1:0]   w_win_key;
    logic [DATA_W-1:0]   r_core_pt;
    logic [DATA_W-1:0]   r_core_k0;
    logic [DATA_W-1:0]   r_rsp_ct;
    logic                r_start;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [TMO_W-1:0]    r_tmo;
    logic [CNT_W-1:0]    r_done_cnt;
    logic                w_tmo_hit;
    logic                w_core_done;
    logic                w_rsp_hs;

    assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT));
    assign w_core_done = (r_state == S_WAIT_DONE) && bus_if.core_valid_i;
    assign w_rsp_hs    = r_rsp_valid && bus_if.rsp_ready_i;

    // Winner search: first valid requester upward from pointer+1, with wrap
    always_comb begin
        logic [ID_W-1:0] v_sel;
        v_sel     = '0;
        w_found   = 1'b0;
        w_win_idx = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            v_sel = ID_W'((32'(r_ptr) + k) % N_REQ);
            if (!w_found && bus_if.req_valid_i[v_sel]) begin
                w_found   = 1'b1;
                w_win_idx = v_sel;
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        w_win_pt  = '0;
        w_win_key = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_win_idx == ID_W'(i)) begin
                w_win_pt  = bus_if.req_pt_i[DATA_W*i +: DATA_W];
                w_win_key = bus_if.req_key_i[DATA_W*i +: DATA_W];
            end
        end
    end

    // Handshake is combinational in IDLE; suppressed while reset is asserted
    assign bus_if.req_ready_o = (r_state == S_IDLE && w_found && rst_n)
                              ? (N_REQ'(1) << w_win_idx) : '0;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_found) w_state_nxt = S_LAUNCH;
            S_LAUNCH:    w_state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (w_tmo_hit)                  w_state_nxt = S_RESP;
                else if (!bus_if.core_valid_i)  w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (w_core_done || w_tmo_hit) w_state_nxt = S_RESP;
            S_RESP:      if (w_rsp_hs) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Operand capture, start pulse, timeout counter and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= ID_W'(N_REQ - 1);
            r_id        <= '0;
            r_core_pt   <= '0;
            r_core_k0   <= '0;
            r_start     <= 1'b0;
            r_tmo       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_ct    <= '0;
            r_rsp_err   <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_core_pt <= w_win_pt;
                        r_core_k0 <= w_win_key;
                        r_id      <= w_win_idx;
                        r_ptr     <= w_win_idx;
                        r_start   <= 1'b1;
                    end
                end
                S_LAUNCH: r_tmo <= '0;
                S_WAIT_LOW, S_WAIT_DONE: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (w_core_done) begin
                        r_rsp_ct    <= bus_if.core_ct_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                    end else if (w_tmo_hit) begin
                        r_rsp_ct    <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_done_cnt  <= r_done_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_if.core_start_o = r_start;
    assign bus_if.core_pt_o    = r_core_pt;
    assign bus_if.core_k0_o    = r_core_k0;
    assign bus_if.rsp_valid_o  = r_rsp_valid;
    assign bus_if.rsp_id_o     = r_id;
    assign bus_if.rsp_ct_o     = r_rsp_ct;
    assign bus_if.rsp_err_o    = r_rsp_err;
    assign bus_if.busy_o       = (r_state != S_IDLE);
    assign bus_if.done_cnt_o   = r_done_cnt;

endmodule

// File: tb/tb_simon_req_arbiter.sv
// Directed testbench for simon_req_arbiter with a behavioural 68-round core model.
module tb_simon_req_arbiter;
    localparam int unsigned N_REQ   = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned TIMEOUT = 96;
    localparam logic [127:0] PT0  = 128'h63736564207372656c6c657661727420;
    localparam logic [127:0] KEY0 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] CT0  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_done = 0;

    simon_req_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) u_if ();

    simon_req_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (u_if)
    );

    always #5 clk = ~clk;

    // Core stand-in: known SIMON vector, otherwise a simple keyed scramble
    function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [127:0] key);
        if (pt == PT0 && key == KEY0) return CT0;
        return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_5a5a_0f0f_0f0f_a5a5_a5a5_f0f0_f0f0;
    endfunction

    function automatic logic [127:0] rr_pt(input int i);
        return 128'h0123_4567_89ab_cdef_0011_2233_4455_6677 ^ 128'(i * 32'h0101_0101);
    endfunction

    function automatic logic [127:0] rr_key(input int i);
        return 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff ^ (128'(i + 1) << 40);
    endfunction

    // Core model: valid sticky, cleared by start, rises 69 cycles after it falls
    logic         m_valid;
    logic [127:0] m_ct;
    int           m_cnt;
    bit           m_hang = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_ct    <= '0;
        end else if (u_if.core_start_o) begin
            m_valid <= 1'b0;
            m_cnt   <= m_hang ? 0 : 69;
            m_ct    <= model_ct(u_if.core_pt_o, u_if.core_k0_o);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_valid <= 1'b1;
        end
    end

    assign u_if.core_valid_i = m_valid;
    assign u_if.core_ct_i    = m_ct;

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [127:0] pt, input logic [127:0] key);
        u_if.req_valid_i[i]          = 1'b1;
        u_if.req_pt_i[128*i +: 128]  = pt;
        u_if.req_key_i[128*i +: 128] = key;
    endtask

    // Steps until rsp_valid; requester valids are masked by keep after the handshake cycle
    task automatic wait_rsp(input int budget, input logic [N_REQ-1:0] keep,
                            output int lat, output int n_start, output int st_cyc);
        lat = -1; n_start = 0; st_cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            nxt();
            if (k == 1) u_if.req_valid_i = u_if.req_valid_i & keep;
            #1;
            if (u_if.core_start_o) begin
                n_start++;
                if (st_cyc < 0) st_cyc = k;
            end
            if (u_if.rsp_valid_o) begin
                lat = k;
                break;
            end
        end
    endtask

    // Finds the granted index, checking the current cycle first
    task automatic wait_grant(input int budget, output int g);
        g = -1;
        for (int k = 0; k <= budget; k++) begin
            if (k > 0) begin nxt(); #1; end
            if (u_if.req_ready_o != '0) begin
                for (int i = 0; i < N_REQ; i++) if (u_if.req_ready_o[i]) g = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        nxt();
        rst_n = 1'b0;
        u_if.req_valid_i = '0;
        u_if.rsp_ready_i = 1'b0;
        nxt();
        rst_n = 1'b1;
        exp_done = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        nxt(); nxt(); #1;
        n_vec++; if (u_if.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", u_if.busy_o); end
        n_vec++; if (u_if.req_ready_o !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", u_if.req_ready_o); end
        n_vec++; if (u_if.core_start_o !== 1'b0) begin n_err++; $display("FAIL reset_start: got %0b want 0", u_if.core_start_o); end
        n_vec++; if ({u_if.core_pt_o, u_if.core_k0_o} !== 256'h0) begin n_err++; $display("FAIL reset_operands: got %0h %0h want 0", u_if.core_pt_o, u_if.core_k0_o); end
        n_vec++; if (u_if.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %0b want 0", u_if.rsp_valid_o); end
        n_vec++; if ({u_if.rsp_id_o, u_if.rsp_ct_o, u_if.rsp_err_o} !== '0) begin n_err++; $display("FAIL reset_rsp_fields: got id %0d ct %0h err %0b want 0", u_if.rsp_id_o, u_if.rsp_ct_o, u_if.rsp_err_o); end
        n_vec++; if (u_if.done_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_done_cnt: got %0d want 0", u_if.done_cnt_o); end
        nxt();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int lat, ns, sc;
        nxt();
        set_req(2, PT0, KEY0);
        #1;
        n_vec++; if (u_if.req_ready_o !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", u_if.req_ready_o); end
        wait_rsp(100, 4'b0000, lat, ns, sc);
        n_vec++; if (lat != 72) begin n_err++; $display("FAIL single_latency: got %0d want 72", lat); end
        n_vec++; if (ns != 1 || sc != 1) begin n_err++; $display("FAIL single_start: got %0d pulses first at %0d want 1 at 1", ns, sc); end
        n_vec++; if (u_if.rsp_id_o !== 2'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", u_if.rsp_id_o); end
        n_vec++; if (u_if.rsp_ct_o !== CT0) begin n_err++; $display("FAIL single_ct: got %0h want %0h", u_if.rsp_ct_o, CT0); end
        n_vec++; if (u_if.rsp_err_o !== 1'b0) begin n_err++; $display("FAIL single_err: got %0b want 0", u_if.rsp_err_o); end
        u_if.rsp_ready_i = 1'b1;
        nxt();
        u_if.rsp_ready_i = 1'b0;
        #1;
        exp_done++;
        n_vec++; if (u_if.done_cnt_o !== 16'(exp_done)) begin n_err++; $display("FAIL single_done_cnt: got %0d want %0d", u_if.done_cnt_o, exp_done); end
        n_vec++; if (u_if.rsp_valid_o !== 1'b0 || u_if.busy_o !== 1'b0) begin n_err++; $display("FAIL single_idle: got valid %0b busy %0b want 0 0", u_if.rsp_valid_o, u_if.busy_o); end
    endtask

    task automatic test_round_robin();
        int g, lat, ns, sc;
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, rr_pt(i), rr_key(i));
        u_if.rsp_ready_i = 1'b1;
        #1;
        for (int j = 0; j < 5; j++) begin
            wait_grant(20, g);
            n_vec++; if (g != j % N_REQ) begin n_err++; $display("FAIL rr_grant%0d: got %0d want %0d", j, g, j % N_REQ); end
            n_vec++; if ($countones(u_if.req_ready_o) != 1) begin n_err++; $display("FAIL rr_onehot%0d: got %b want one-hot", j, u_if.req_ready_o); end
            wait_rsp(100, 4'b1111, lat, ns, sc);
            n_vec++; if (lat != 72) begin n_err++; $display("FAIL rr_latency%0d: got %0d want 72", j, lat); end
            n_vec++; if (32'(u_if.rsp_id_o) != g) begin n_err++; $display("FAIL rr_id%0d: got %0d want %0d", j, u_if.rsp_id_o, g); end
            n_vec++; if (g >= 0 && u_if.rsp_ct_o !== model_ct(rr_pt(g), rr_key(g))) begin n_err++; $display("FAIL rr_ct%0d: got %0h want %0h", j, u_if.rsp_ct_o, model_ct(rr_pt(g), rr_key(g))); end
        end
        nxt();
        u_if.req_valid_i = '0;
        u_if.rsp_ready_i = 1'b0;
        #1;
        exp_done = 5;
        n_vec++; if (u_if.done_cnt_o !== 16'd5) begin n_err++; $display("FAIL rr_done_cnt: got %0d want 5", u_if.done_cnt_o); end
        n_vec++; if (u_if.busy_o !== 1'b0) begin n_err++; $display("FAIL rr_idle: got busy %0b want 0", u_if.busy_o); end
    endtask

    task automatic test_back_to_back();
        int lat, ns, sc;
        logic [127:0] pb, kb, p3, k3;
        pb = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        kb = 128'h0badc0de_0badc0de_0badc0de_0badc0de;
        p3 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        k3 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        nxt();
        set_req(1, pb, kb);
        set_req(3, p3, k3);
        #1;
        n_vec++; if (u_if.req_ready_o !== 4'b0010) begin n_err++; $display("FAIL bp_grant: got %b want 0010", u_if.req_ready_o); end
        wait_rsp(100, 4'b1000, lat, ns, sc);
        n_vec++; if (lat != 72) begin n_err++; $display("FAIL bp_latency: got %0d want 72", lat); end
        for (int c = 0; c < 10; c++) begin
            nxt(); #1;
            n_vec++;
            if ({u_if.rsp_valid_o, u_if.rsp_id_o, u_if.rsp_ct_o, u_if.rsp_err_o} !== {1'b1, 2'd1, model_ct(pb, kb), 1'b0}) begin
                n_err++; $display("FAIL bp_hold%0d: got valid %0b id %0d ct %0h want 1 1 %0h", c, u_if.rsp_valid_o, u_if.rsp_id_o, u_if.rsp_ct_o, model_ct(pb, kb));
            end
            n_vec++;
            if (u_if.req_ready_o !== 4'b0000 || u_if.done_cnt_o !== 16'(exp_done)) begin
                n_err++; $display("FAIL bp_quiet%0d: got ready %b done %0d want 0000 %0d", c, u_if.req_ready_o, u_if.done_cnt_o, exp_done);
            end
        end
        u_if.rsp_ready_i = 1'b1;
        nxt();
        u_if.rsp_ready_i = 1'b0;
        #1;
        exp_done++;
        n_vec++; if (u_if.done_cnt_o !== 16'(exp_done)) begin n_err++; $display("FAIL bp_done_cnt: got %0d want %0d", u_if.done_cnt_o, exp_done); end
        n_vec++; if (u_if.req_ready_o !== 4'b1000) begin n_err++; $display("FAIL b2b_grant: got %b want 1000", u_if.req_ready_o); end
        wait_rsp(100, 4'b0000, lat, ns, sc);
        n_vec++; if (lat != 72 || u_if.rsp_id_o !== 2'd3) begin n_err++; $display("FAIL b2b_rsp: got lat %0d id %0d want 72 3", lat, u_if.rsp_id_o); end
        n_vec++; if (u_if.rsp_ct_o !== model_ct(p3, k3)) begin n_err++; $display("FAIL b2b_ct: got %0h want %0h", u_if.rsp_ct_o, model_ct(p3, k3)); end
        u_if.rsp_ready_i = 1'b1;
        nxt();
        u_if.rsp_ready_i = 1'b0;
        #1;
        exp_done++;
        n_vec++; if (u_if.done_cnt_o !== 16'(exp_done)) begin n_err++; $display("FAIL b2b_done_cnt: got %0d want %0d", u_if.done_cnt_o, exp_done); end
    endtask

    task automatic test_timeout();
        int lat, ns, sc;
        nxt();
        m_hang = 1'b1;
        set_req(0, 128'h77, 128'h99);
        #1;
        n_vec++; if (u_if.req_ready_o !== 4'b0001) begin n_err++; $display("FAIL tmo_grant: got %b want 0001", u_if.req_ready_o); end
        wait_rsp(TIMEOUT + 20, 4'b0000, lat, ns, sc);
        n_vec++; if (lat != int'(TIMEOUT) + 3) begin n_err++; $display("FAIL tmo_latency: got %0d want %0d", lat, TIMEOUT + 3); end
        n_vec++; if (u_if.rsp_err_o !== 1'b1 || u_if.rsp_ct_o !== 128'h0) begin n_err++; $display("FAIL tmo_rsp: got err %0b ct %0h want 1 0", u_if.rsp_err_o, u_if.rsp_ct_o); end
        n_vec++; if (u_if.rsp_id_o !== 2'd0) begin n_err++; $display("FAIL tmo_id: got %0d want 0", u_if.rsp_id_o); end
        u_if.rsp_ready_i = 1'b1;
        nxt();
        u_if.rsp_ready_i = 1'b0;
        m_hang = 1'b0;
        #1;
        exp_done++;
        n_vec++; if (u_if.done_cnt_o !== 16'(exp_done)) begin n_err++; $display("FAIL tmo_done_cnt: got %0d want %0d", u_if.done_cnt_o, exp_done); end
    endtask

    task automatic test_reset_mid();
        int seen;
        nxt();
        set_req(3, 128'h3333, 128'h4444);
        #1;
        n_vec++; if (u_if.req_ready_o !== 4'b1000) begin n_err++; $display("FAIL mid_grant: got %b want 1000", u_if.req_ready_o); end
        for (int k = 1; k <= 20; k++) begin
            nxt();
            if (k == 1) u_if.req_valid_i = '0;
            #1;
        end
        n_vec++; if (u_if.busy_o !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %0b want 1", u_if.busy_o); end
        nxt();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        #1;
        exp_done = 0;
        n_vec++; if (u_if.busy_o !== 1'b0 || u_if.core_start_o !== 1'b0 || u_if.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_ctrl: got busy %0b start %0b valid %0b want 0 0 0", u_if.busy_o, u_if.core_start_o, u_if.rsp_valid_o); end
        n_vec++; if ({u_if.core_pt_o, u_if.core_k0_o} !== 256'h0 || u_if.done_cnt_o !== 16'd0) begin n_err++; $display("FAIL mid_regs: got pt %0h done %0d want 0 0", u_if.core_pt_o, u_if.done_cnt_o); end
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            nxt(); #1;
            if (u_if.rsp_valid_o || u_if.busy_o) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL mid_no_rsp: got %0d active cycles want 0", seen); end
        nxt();
        set_req(0, 128'h1, 128'h2);
        set_req(3, 128'h3, 128'h4);
        #1;
        n_vec++; if (u_if.req_ready_o !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant: got %b want 0001", u_if.req_ready_o); end
        u_if.req_valid_i = '0;
    endtask

    task automatic test_operand_stability();
        logic [127:0] pa, ka;
        int bad, got;
        pa = 128'hcafe_f00d_1234_5678_9abc_def0_1357_9bdf;
        ka = 128'h2468_ace0_1122_3344_5566_7788_99aa_bbcc;
        bad = 0; got = 0;
        nxt();
        set_req(2, pa, ka);
        #1;
        n_vec++; if (u_if.req_ready_o !== 4'b0100) begin n_err++; $display("FAIL stab_grant: got %b want 0100", u_if.req_ready_o); end
        for (int k = 1; k <= 100 && got == 0; k++) begin
            nxt();
            if (k == 1) begin
                u_if.req_valid_i = '0;
                u_if.req_pt_i[256 +: 128]  = ~pa;
                u_if.req_key_i[256 +: 128] = ~ka;
            end
            #1;
            n_vec++;
            if (u_if.core_pt_o !== pa || u_if.core_k0_o !== ka) begin
                n_err++; $display("FAIL stab_cyc%0d: got pt %0h key %0h want %0h %0h", k, u_if.core_pt_o, u_if.core_k0_o, pa, ka);
            end
            if (u_if.rsp_valid_o) got = k;
        end
        n_vec++; if (got != 72) begin n_err++; $display("FAIL stab_latency: got %0d want 72", got); end
        n_vec++; if (u_if.rsp_ct_o !== model_ct(pa, ka)) begin n_err++; $display("FAIL stab_ct: got %0h want %0h", u_if.rsp_ct_o, model_ct(pa, ka)); end
        u_if.rsp_ready_i = 1'b1;
        nxt();
        u_if.rsp_ready_i = 1'b0;
        #1;
        exp_done++;
        n_vec++; if (u_if.done_cnt_o !== 16'(exp_done)) begin n_err++; $display("FAIL stab_done_cnt: got %0d want %0d", u_if.done_cnt_o, exp_done); end
        n_vec++; if (u_if.core_pt_o !== pa) begin n_err++; $display("FAIL stab_after: got %0h want %0h", u_if.core_pt_o, pa); end
    endtask

    initial begin
        u_if.req_valid_i = '0;
        u_if.req_pt_i    = '0;
        u_if.req_key_i   = '0;
        u_if.rsp_ready_i = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_operand_stability();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/simon_req_arbiter.md
Name: simon_req_arbiter

Overview:
- Round-robin scheduler that shares one SIMON 128/128 encryption core between N_REQ requesters.
- Accepts plaintext/key jobs over per-requester valid/ready handshakes and holds the operands stable to the core for the whole run.
- Issues the core start pulse, detects completion from the core's sticky valid, and returns the ciphertext tagged with the requester ID over a valid/ready response port.
- Sits between the requester ports and the core top level; the core shares clk and rst_n.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, $clog2(N_REQ), response ID width
TIMEOUT, 96, max cycles spent waiting for the core before an error response

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid_i  in  N_REQ  per-requester job valid
req_ready_o  out  N_REQ  per-requester accept (one-hot or zero)
req_pt_i  in  N_REQ*128  plaintexts; requester i at [128*i +: 128]
req_key_i  in  N_REQ*128  keys; same packing
core_start_o  out  1  one-cycle start pulse to the core
core_pt_o  out  128  plaintext to the core
core_k0_o  out  128  initial key to the core
core_valid_i  in  1  core valid (sticky; cleared by start)
core_ct_i  in  128  core ciphertext
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_id_o  out  ID_W  index of the requester that owns the response
rsp_ct_o  out  128  ciphertext (zero on error)
rsp_err_o  out  1  timeout flag for this response
busy_o  out  1  high in any state except IDLE
done_cnt_o  out  16  count of completed (rsp-handshaken) jobs, wraps

Behaviour:
- Reset (rst_n low at a clock edge):
  - FSM goes to IDLE; round-robin pointer goes to N_REQ-1, so requester 0 wins first.
  - All outputs are zero: req_ready_o, core_start_o, core_pt_o, core_k0_o, rsp_*, busy_o, done_cnt_o.
  - Reset mid-job abandons the job with no response. The core is reset by the same rst_n.
- FSM states: IDLE, LAUNCH, WAIT_LOW, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid_i is high, grant the first requester found searching upward, with wrap, from pointer+1.
  - req_ready_o is driven combinationally this cycle, one-hot on the winner. That cycle is the handshake.
  - At the clock edge: capture the winner's pt, key and index into core_pt_o, core_k0_o and the ID register; set pointer to the winner; go to LAUNCH.
  - With no request, stay in IDLE with req_ready_o all zero.
- LAUNCH: core_start_o=1 for exactly this one cycle; go to WAIT_LOW.
- WAIT_LOW: wait for core_valid_i==0, which acknowledges that the core consumed start; then go to WAIT_DONE.
- WAIT_DONE: on core_valid_i==1, register core_ct_i into rsp_ct_o, set rsp_err_o=0, go to RESP.
- Operand stability: core_pt_o and core_k0_o hold their captured values from LAUNCH until the next grant.
- Timeout:
  - A cycle counter is cleared in LAUNCH and increments in WAIT_LOW and WAIT_DONE.
  - When it reaches TIMEOUT: go to RESP with rsp_err_o=1 and rsp_ct_o=0.
  - Recovery of the core after a timeout is a system reset; the arbiter does not retry.
- RESP:
  - rsp_valid_o=1; rsp_id_o, rsp_ct_o and rsp_err_o are held stable until rsp_ready_i.
  - On rsp_valid_o && rsp_ready_i: done_cnt_o increments (wraps 0xFFFF->0), then go to IDLE.
  - No new grant is made in the handshake cycle itself.
- Timing with the 68-round core:
  - Request handshake at cycle T; core_start_o at T+1.
  - core_valid_i falls at T+2 and rises at T+71; rsp_valid_o rises at T+72.
  - Back-to-back jobs: next grant no earlier than the cycle after the rsp handshake.
- Simultaneous events:
  - Requests arriving while not in IDLE see req_ready_o=0 and must hold their valid and data.
  - A requester dropping req_valid_i before being granted is simply skipped.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0.
- busy_o = (state != IDLE).

Test Plan:
- Single job: after reset, requester 2 sends pt=0x63736564207372656c6c657661727420, key=0x0f0e0d0c0b0a09080706050403020100 -> req_ready_o=4'b0100 for one cycle; one core_start_o pulse; rsp_valid_o at T+72 with rsp_id_o=2, rsp_ct_o=0x49681b1e1e54fe3f65aa832af84e0bbc, rsp_err_o=0, done_cnt_o=1.
- Round robin: all four requesters valid continuously, rsp_ready_i=1 -> grant order 0,1,2,3,0; each response ID matches its grant; done_cnt_o=5.
- Response backpressure: rsp_ready_i held low for 10 cycles -> rsp_valid_o, rsp_id_o and rsp_ct_o stable throughout; no req_ready_o asserted; exactly one done_cnt_o increment after release.
- Timeout: core model never raises core_valid_i -> rsp_valid_o with rsp_err_o=1 and rsp_ct_o=0, TIMEOUT+3 cycles after the handshake.
- Reset mid-job: rst_n low during WAIT_DONE -> next cycle state IDLE, all outputs zero, no response emitted; a following request from requester 0 is granted first.
- Operand stability: requester changes req_pt_i after the handshake -> core_pt_o unchanged until the job's rsp handshake.
